up_sampler: RTL and testbench
=============================

# up_sampler

Integer-factor interpolating up-sampler for the pre-processing filter chain. It is the counterpart of the down-sampler: it turns a decimated, strobed sample stream back into a dense stream of 2^LOG2_FACTOR output samples per input interval. Adjacent samples are linearly interpolated by default, and the stream is paced by a one-entry input buffer with a ready handshake.

## Interface
- Width, 10, sample width in bits (signed two's complement, in and out)
- LOG2_FACTOR, 1, up-sampling factor L = 2^LOG2_FACTOR; legal range 1..4
- clk  input  1  system clock, rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  output-side enable; freezes interpolation when low
- data_in  input  Width  signed input sample
- valid_in  input  1  data_in is valid this cycle
- ready_out  input-side  output  1  high when the pending buffer is empty; a sample transfers on valid_in && ready_out
- data_out  output  Width  signed interpolated sample, registered
- valid_out  output  1  data_out is new this cycle, registered

## Operation
- Registers:
  - pend, pend_v: one-entry input buffer
  - prev, curr: interpolation window
  - phase: LOG2_FACTOR-bit counter
  - state
- ready_out = !pend_v, taken directly from the register.
- Input acceptance is independent of en. A transfer sets pend_v and loads pend.
- States:
  - EMPTY: no samples held. If pend_v: curr<=pend, pend_v<=0, go to PRIMED.
  - PRIMED: curr held, waiting for the next sample. If pend_v: prev<=curr, curr<=pend, pend_v<=0, phase<=0, go to RUN.
  - RUN: emits one sample per en cycle.
    - Each en cycle: data_out<=interp(phase), valid_out<=1.
    - phase<L-1: phase increments.
    - phase==L-1 and pend_v: reload the window as in PRIMED, phase<=0, stay in RUN.
    - phase==L-1 and !pend_v: go to PRIMED (curr retained).
- interp(k), with UPSAMPLER_LINEAR_INTERP_EN defined:
  - diff = curr - prev in Width+1 bits
  - prod = diff*k in Width+1+LOG2_FACTOR bits
  - result = prev + (prod >>> LOG2_FACTOR), arithmetic shift (floor)
  - The result always lies in [min(prev,curr), max(prev,curr)], so it is truncated to Width without overflow.
- valid_out is 0 on every cycle that is not a RUN-state en cycle. data_out holds its last value when valid_out=0.
- en low in RUN: phase, window and pend are frozen, valid_out=0, and input acceptance continues.
- Simultaneous offer and consume: when pend is consumed on an edge, ready_out was already low that cycle. The buffer frees on the following cycle, so no data is ever lost or overwritten.

## Timing
- Reset values:
  - state=EMPTY, pend_v=0, phase=0
  - prev=curr=pend=0
  - data_out=0, valid_out=0, ready_out=1
- Reset asserted mid-operation clears all state immediately (asynchronously); the partial window is discarded.
- Startup latency:
  - First sample: accepted at edge N, moves to curr at N+1.
  - Second sample: accepted at edge M, window loaded at M+1, first valid_out at M+2, with data_out=prev.
- Steady state, en=1 and one input every L cycles: valid_out continuously high with no bubbles.
- Sustained input faster than 1/L: back-pressure through ready_out. Slower input: valid_out gaps while in PRIMED.
- Throughput: exactly L outputs per accepted sample (after the first sample).

## Configuration
- UPSAMPLER_LINEAR_INTERP_EN
  - Defined: linear interpolation as specified under Operation.
  - Undefined: zero-order hold; interp(k)=prev for all k. The multiplier and difference logic are not synthesised. State machine, handshake and timing are identical.

## Test plan
- L=2, linear, en=1; inputs 0,10,20,30 spaced 2 cycles apart -> valid_out stream 0,5,10,15,20,25 with no gaps; first valid_out two cycles after the edge accepting 10.
- L=4, linear; inputs 0 then -7 -> outputs 0,-2,-4,-6 (floor rounding of negative slope).
- L=2; inputs -8 then 3 -> outputs -8,-3. Width=10 extremes: 511 then -512 -> 511,-1 (no overflow).
- Back-pressure, L=4: valid_in held high with values 1,2,3,4 -> ready_out drops after each accept, samples transfer once per window, outputs are monotone with no sample dropped or duplicated.
- en toggled low for 3 cycles mid-window at phase 1 -> valid_out=0 for 3 cycles, then the stream resumes at phase 2 with the correct value.
- rst_n pulsed low mid-RUN -> all outputs 0 and ready_out=1 immediately. Two new samples are then required before valid_out; the macro-off build of the first scenario emits 0,0,10,10,20,20.

Source files
------------

// File: rtl/up_sampler.sv
// up_sampler -- integer-factor interpolating up-sampler.
//
// Turns a strobed, decimated sample stream into 2^LOG2_FACTOR output samples
// per input interval. A one-entry buffer (pend) decouples the input handshake
// from the output pacing, and a two-sample window (prev, curr) feeds the
// interpolator.
//
// Optional feature macro: UPSAMPLER_LINEAR_INTERP_EN
//   defined   : linear interpolation between prev and curr (floor rounding)
//   undefined : zero-order hold, every output of a window equals prev
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         output-side enable; freezes the RUN window when low
//   data_in    signed input sample
//   valid_in   data_in valid this cycle
//   ready_out  buffer empty; a sample transfers on valid_in && ready_out
//   data_out   signed interpolated sample (registered)
//   valid_out  data_out is new this cycle (registered)
module up_sampler #(
  parameter int Width       = 10,
  parameter int LOG2_FACTOR = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [Width-1:0] data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic signed [Width-1:0] data_out,
  output logic                    valid_out
);

  localparam int                     L    = 1 << LOG2_FACTOR;
  localparam logic [LOG2_FACTOR-1:0] LAST = LOG2_FACTOR'(L - 1);

  typedef enum logic [1:0] {EMPTY, PRIMED, RUN} state_t;

  state_t                  state;
  logic signed [Width-1:0] pend;
  logic signed [Width-1:0] prev;
  logic signed [Width-1:0] curr;
  logic                    pend_v;
  logic [LOG2_FACTOR-1:0]  phase;
  logic                    accept;
  logic                    consume;
  logic signed [Width-1:0] interp_val;

`ifdef UPSAMPLER_LINEAR_INTERP_EN
  // prev + floor((curr - prev) * k / L). The result always lies between prev
  // and curr, so the low Width bits are exact.
  function automatic logic signed [Width-1:0] interp(
    input logic signed [Width-1:0]       p,
    input logic signed [Width-1:0]       c,
    input logic        [LOG2_FACTOR-1:0] k
  );
    logic signed [Width:0]             diff;
    logic signed [Width+LOG2_FACTOR:0] prod;
    logic signed [Width+LOG2_FACTOR:0] sum;
    diff = {c[Width-1], c} - {p[Width-1], p};
    prod = $signed({{LOG2_FACTOR{diff[Width]}}, diff})
         * $signed({{(Width+1){1'b0}}, k});
    sum  = {{(LOG2_FACTOR+1){p[Width-1]}}, p} + (prod >>> LOG2_FACTOR);
    return sum[Width-1:0];
  endfunction

  assign interp_val = interp(prev, curr, phase);
`else
  assign interp_val = prev;
`endif

  // The buffer is the only source of back-pressure; taking ready straight
  // from the register keeps the handshake free of combinational paths.
  assign ready_out = !pend_v;
  assign accept    = valid_in && !pend_v;

  // pend is drained when a window (re)load or the first prime takes it.
  // accept and consume are mutually exclusive because each needs the
  // opposite pend_v value.
  assign consume = pend_v && ((state == EMPTY) || (state == PRIMED) ||
                              ((state == RUN) && en && (phase == LAST)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      pend      <= '0;
      pend_v    <= 1'b0;
      prev      <= '0;
      curr      <= '0;
      phase     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;

      if (accept) begin
        pend   <= data_in;
        pend_v <= 1'b1;
      end else if (consume) begin
        pend_v <= 1'b0;
      end

      case (state)
        EMPTY: begin
          if (pend_v) begin
            curr  <= pend;
            state <= PRIMED;
          end
        end
        PRIMED: begin
          if (pend_v) begin
            prev  <= curr;
            curr  <= pend;
            phase <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (en) begin
            data_out  <= interp_val;
            valid_out <= 1'b1;
            // Wraps to zero after the last phase of the window.
            phase     <= phase + LOG2_FACTOR'(1);
            if (phase == LAST) begin
              if (pend_v) begin
                prev <= curr;
                curr <= pend;
              end else begin
                state <= PRIMED;
              end
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_up_sampler.sv
// tb_up_sampler -- scoreboard bench for up_sampler.
// Two instances share a clock: u2 (factor 2) and u4 (factor 4). Expected
// output samples are queued per instance when stimulus is issued and a
// monitor pops and compares them whenever valid_out is high.
module tb_up_sampler;

  typedef logic signed [9:0] sample_t;

`ifdef UPSAMPLER_LINEAR_INTERP_EN
  localparam bit LIN = 1'b1;
`else
  localparam bit LIN = 1'b0;
`endif

  logic    clk = 1'b0;
  logic    rst2_n, rst4_n, en2, en4, vin2, vin4;
  sample_t din2, din4, dout2, dout4;
  logic    rdy2, rdy4, vo2, vo4;

  sample_t q2[$];
  sample_t q4[$];
  int      checks = 0;
  int      errors = 0;

  always #5 clk = ~clk;

  up_sampler #(.Width(10), .LOG2_FACTOR(1)) u2 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .data_in(din2), .valid_in(vin2),
    .ready_out(rdy2), .data_out(dout2), .valid_out(vo2)
  );

  up_sampler #(.Width(10), .LOG2_FACTOR(2)) u4 (
    .clk(clk), .rst_n(rst4_n), .en(en4), .data_in(din4), .valid_in(vin4),
    .ready_out(rdy4), .data_out(dout4), .valid_out(vo4)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push2(input int lin_v, input int zoh_v);
    q2.push_back(sample_t'(LIN ? lin_v : zoh_v));
  endtask

  task automatic push4(input int lin_v, input int zoh_v);
    q4.push_back(sample_t'(LIN ? lin_v : zoh_v));
  endtask

  task automatic send2(input int v);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy2 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!rdy2) begin
      checks++;
      errors++;
      $display("FAIL send2_ready got %0d expected 1", rdy2);
    end
    vin2 = 1'b1;
    din2 = sample_t'(v);
    @(negedge clk);
    vin2 = 1'b0;
  endtask

  task automatic send4(input int v);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy4 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!rdy4) begin
      checks++;
      errors++;
      $display("FAIL send4_ready got %0d expected 1", rdy4);
    end
    vin4 = 1'b1;
    din4 = sample_t'(v);
    @(negedge clk);
    vin4 = 1'b0;
  endtask

  task automatic pulse2;
    @(negedge clk);
    rst2_n = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;
  endtask

  task automatic pulse4;
    @(negedge clk);
    rst4_n = 1'b0;
    @(negedge clk);
    rst4_n = 1'b1;
  endtask

  // Monitor: compares every presented output against the scoreboard queues.
  initial begin
    sample_t e;
    forever begin
      @(negedge clk);
      if (vo2) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL u2_unexpected got %0d expected none", dout2);
        end else begin
          e = q2.pop_front();
          if (dout2 !== e) begin
            errors++;
            $display("FAIL u2_data got %0d expected %0d", dout2, e);
          end
        end
      end
      if (vo4) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL u4_unexpected got %0d expected none", dout4);
        end else begin
          e = q4.pop_front();
          if (dout4 !== e) begin
            errors++;
            $display("FAIL u4_data got %0d expected %0d", dout4, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1_in[4]   = '{0, 10, 20, 30};
    int s1_lin[6]  = '{0, 5, 10, 15, 20, 25};
    int s1_zoh[6]  = '{0, 0, 10, 10, 20, 20};
    int bp_in[4]   = '{0, 40, 80, 120};
    int bp_lin[12] = '{0, 10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 110};
    int bp_zoh[12] = '{0, 0, 0, 0, 40, 40, 40, 40, 80, 80, 80, 80};
    int i;
    int seen;

    rst2_n = 1'b0; rst4_n = 1'b0;
    en2 = 1'b1; en4 = 1'b1; vin2 = 1'b0; vin4 = 1'b0; din2 = '0; din4 = '0;
    repeat (2) @(negedge clk);
    chk("rst_dout2", dout2, 0);
    chk("rst_vo2", vo2, 0);
    chk("rst_rdy2", rdy2, 1);
    chk("rst_dout4", dout4, 0);
    chk("rst_vo4", vo4, 0);
    chk("rst_rdy4", rdy4, 1);
    rst2_n = 1'b1; rst4_n = 1'b1;

    // Ramp at one input per two cycles: gapless output, latency two edges
    // after the edge accepting the second sample.
    for (int k = 0; k < 6; k++) push2(s1_lin[k], s1_zoh[k]);
    for (int t = 0; t < 13; t++) begin
      @(negedge clk);
      chk("s1_valid", int'(vo2), (t >= 5 && t <= 10) ? 1 : 0);
      if ((t % 2 == 0) && (t < 8)) begin
        chk("s1_ready", int'(rdy2), 1);
        vin2 = 1'b1;
        din2 = sample_t'(s1_in[t / 2]);
      end else begin
        vin2 = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    chk("s1_drain", q2.size(), 0);

    // Negative slope with floor rounding, factor 4.
    push4(0, 0); push4(-2, 0); push4(-4, 0); push4(-6, 0);
    send4(0);
    send4(-7);
    repeat (10) @(negedge clk);
    chk("neg_drain", q4.size(), 0);

    // Mixed sign, factor 2.
    pulse2;
    push2(-8, -8); push2(-3, -8);
    send2(-8);
    send2(3);
    repeat (8) @(negedge clk);
    chk("mix_drain", q2.size(), 0);

    // Full-scale extremes must not overflow.
    pulse2;
    push2(511, 511); push2(-1, 511);
    send2(511);
    send2(-512);
    repeat (8) @(negedge clk);
    chk("ext_drain", q2.size(), 0);

    // Back-pressure: valid_in held high, one transfer per window.
    pulse4;
    for (int k = 0; k < 12; k++) push4(bp_lin[k], bp_zoh[k]);
    @(negedge clk);
    vin4 = 1'b1;
    din4 = sample_t'(bp_in[0]);
    i = 0;
    for (int g = 0; g < 200 && i < 4; g++) begin
      if (rdy4) begin
        @(negedge clk);
        chk("bp_ready_drop", int'(rdy4), 0);
        i++;
        if (i < 4) din4 = sample_t'(bp_in[i]);
        else vin4 = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    vin4 = 1'b0;
    chk("bp_accepts", i, 4);
    repeat (20) @(negedge clk);
    chk("bp_drain", q4.size(), 0);

    // en low for three cycles after phase 1 has been emitted.
    pulse4;
    push4(-100, -100); push4(-50, -100); push4(0, -100); push4(50, -100);
    send4(-100);
    send4(100);
    seen = 0;
    for (int g = 0; g < 20 && seen < 2; g++) begin
      @(negedge clk);
      if (vo4) seen++;
    end
    chk("en_wait", seen, 2);
    en4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("en_low_valid", int'(vo4), 0);
    end
    en4 = 1'b1;
    repeat (8) @(negedge clk);
    chk("en_drain", q4.size(), 0);

    // Reset in the middle of RUN with a sample pending.
    pulse2;
    push2(200, 200);
    send2(200);
    send2(100);
    send2(50);
    chk("mr_valid_before", int'(vo2), 1);
    chk("mr_ready_before", int'(rdy2), 0);
    #2 rst2_n = 1'b0;
    #1;
    chk("mr_dout", dout2, 0);
    chk("mr_valid", int'(vo2), 0);
    chk("mr_ready", int'(rdy2), 1);
    chk("mr_queue", q2.size(), 0);
    @(negedge clk);
    rst2_n = 1'b1;
    send2(7);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mr_one_sample", int'(vo2), 0);
    end
    push2(7, 7); push2(8, 7);
    send2(9);
    repeat (8) @(negedge clk);
    chk("mr_drain", q2.size(), 0);
    chk("final_q4", q4.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
